// File: rtl/ln_stats_tree_acc.sv
// LayerNorm statistics engine: per-vector rounded mean and mean-of-squares of
// signed fixed-point lanes, via a registered adder tree plus a beat accumulator.
module ln_stats_tree_acc #(
  parameter int DATA_W     = 16,
  parameter int FRAC       = 8,
  parameter int LANES      = 16,
  parameter int LOG2_BEATS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DATA_W-1:0]      in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_mean,
  output logic [2*DATA_W-FRAC-1:0]     out_msq
);

  localparam int T     = $clog2(LANES);
  localparam int S     = T + LOG2_BEATS;
  localparam int SW    = DATA_W + S;
  localparam int MW    = 2*DATA_W - FRAC;
  localparam int QW    = MW + S;
  localparam int BEATS = 1 << LOG2_BEATS;
  localparam int CW    = (LOG2_BEATS > 0) ? LOG2_BEATS : 1;

  localparam logic signed [SW:0] RND_S    = (SW+1)'((1 << S) >> 1);
  localparam logic        [QW:0] RND_Q    = (QW+1)'((1 << S) >> 1);
  localparam logic signed [SW:0] MEAN_MAX = {{(S+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW:0] MEAN_MIN = {{(S+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic          en;
  logic [CW-1:0] cnt;

  always_comb begin
    en       = !(out_valid && !out_ready);
    in_ready = en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (in_valid && en) begin
      cnt <= (cnt == CW'(BEATS - 1)) ? '0 : cnt + CW'(1);
    end
  end

  // Level 0 is the combinational lane input (value + truncated square);
  // levels 1..T are registered pairwise sums, with valid/last riding along.
  for (genvar l = 0; l <= T; l++) begin : lvl
    localparam int N = LANES >> l;
    logic signed [SW-1:0] s [N];
    logic        [QW-1:0] q [N];
    logic                 v;
    logic                 last;

    if (l == 0) begin : g_src
      always_comb begin : lanes
        logic signed [DATA_W-1:0]   x;
        logic signed [2*DATA_W-1:0] p;
        x    = '0;
        p    = '0;
        v    = in_valid && en;
        last = (cnt == CW'(BEATS - 1));
        for (int unsigned i = 0; i < N; i++) begin
          x    = in_data[i*DATA_W +: DATA_W];
          p    = (2*DATA_W)'(x) * (2*DATA_W)'(x);
          s[i] = SW'(x);
          q[i] = QW'($unsigned(p) >> FRAC);
        end
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (rst) begin
          v    <= 1'b0;
          last <= 1'b0;
        end else if (en) begin
          v    <= lvl[l-1].v;
          last <= lvl[l-1].last;
        end
      end

      always_ff @(posedge clk) begin
        if (en) begin
          for (int unsigned i = 0; i < N; i++) begin
            s[i] <= lvl[l-1].s[2*i] + lvl[l-1].s[2*i+1];
            q[i] <= lvl[l-1].q[2*i] + lvl[l-1].q[2*i+1];
          end
        end
      end
    end
  end

  logic signed [SW-1:0] acc_s, fin_s;
  logic        [QW-1:0] acc_q, fin_q;
  logic                 acc_open, acc_last, fin_valid;

  // acc_open marks a vector in progress; the final sums move to fin_* one
  // cycle later so the next vector's first beat can reload acc_* meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_s     <= '0;
      acc_q     <= '0;
      acc_open  <= 1'b0;
      acc_last  <= 1'b0;
      fin_s     <= '0;
      fin_q     <= '0;
      fin_valid <= 1'b0;
    end else if (en) begin
      acc_last <= lvl[T].v && lvl[T].last;
      if (lvl[T].v) begin
        acc_s    <= acc_open ? acc_s + lvl[T].s[0] : lvl[T].s[0];
        acc_q    <= acc_open ? acc_q + lvl[T].q[0] : lvl[T].q[0];
        acc_open <= !lvl[T].last;
      end
      fin_valid <= acc_last;
      if (acc_last) begin
        fin_s <= acc_s;
        fin_q <= acc_q;
      end
    end
  end

  logic signed [SW:0]       mean_r;
  logic        [QW:0]       msq_r;
  logic        [DATA_W-1:0] mean_n;
  logic        [MW-1:0]     msq_n;

  always_comb begin
    mean_r = ((SW+1)'(fin_s) + RND_S) >>> S;
    msq_r  = ((QW+1)'(fin_q) + RND_Q) >> S;
    if (mean_r > MEAN_MAX) begin
      mean_n = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (mean_r < MEAN_MIN) begin
      mean_n = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      mean_n = mean_r[DATA_W-1:0];
    end
    if (|msq_r[QW:MW]) begin
      msq_n = '1;
    end else begin
      msq_n = msq_r[MW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mean  <= '0;
      out_msq   <= '0;
    end else if (en) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        out_mean <= mean_n;
        out_msq  <= msq_n;
      end
    end
  end

endmodule
